// File: rtl/md5_dispatch_if.sv
// Candidate / core-array / result bundle for md5_dispatch.
// master: the dispatcher itself. slave: the surrounding generator, cores and command layer.
// Optional match counter signal is present only when MD5_DISPATCH_MATCH_COUNT_EN is defined.
interface md5_dispatch_if #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 448,
  parameter int TAG_W     = 16
);
  logic                     target_load;
  logic [127:0]             target_hash;
  logic                     cand_valid;
  logic                     cand_ready;
  logic [DATA_W-1:0]        cand_data;
  logic [TAG_W-1:0]         cand_tag;
  logic                     drain_req;
  logic                     drain_done;
  logic [NUM_CORES-1:0]     core_start;
  logic [DATA_W-1:0]        core_data;
  logic [NUM_CORES-1:0]     core_done;
  logic [NUM_CORES*128-1:0] core_digest;
  logic                     match_valid;
  logic [TAG_W-1:0]         match_tag;
  logic                     busy;
`ifdef MD5_DISPATCH_MATCH_COUNT_EN
  logic [TAG_W-1:0]         match_count;
`endif

  modport master (
    input  target_load, target_hash, cand_valid, cand_data, cand_tag,
           drain_req, core_done, core_digest,
    output cand_ready, drain_done, core_start, core_data, match_valid,
           match_tag, busy
`ifdef MD5_DISPATCH_MATCH_COUNT_EN
    , output match_count
`endif
  );

  modport slave (
    output target_load, target_hash, cand_valid, cand_data, cand_tag,
           drain_req, core_done, core_digest,
    input  cand_ready, drain_done, core_start, core_data, match_valid,
           match_tag, busy
`ifdef MD5_DISPATCH_MATCH_COUNT_EN
    , input match_count
`endif
  );
endinterface

// File: rtl/md5_dispatch.sv
// md5_dispatch: round-robin scheduler of candidate blocks onto NUM_CORES md5 cores,
// owner of the target-hash register, and digest-vs-target checker reporting matches by tag.
// Optional feature: define MD5_DISPATCH_MATCH_COUNT_EN to add a saturating match counter.
module md5_dispatch #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 448,
  parameter int TAG_W     = 16
) (
  input logic            clk,
  input logic            reset,
  md5_dispatch_if.master bus
);

  localparam int IDX_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [127:0]         target_q, target_d;
  logic [NUM_CORES-1:0] alloc_q, alloc_d;
  logic [NUM_CORES-1:0] pend_q, pend_d;
  logic [NUM_CORES-1:0] start_q, start_d;
  logic [DATA_W-1:0]    cdata_q, cdata_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic                 mv_q, mv_d;
  logic [TAG_W-1:0]     mtag_q, mtag_d;
  logic [TAG_W-1:0]     tag_q [NUM_CORES];

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 res_found;
  logic [IDX_W-1:0]     res_idx;
  logic [NUM_CORES-1:0] clr_mask;
  logic                 cand_ready_s;
  logic                 drain_done_s;
  logic                 accept;
  logic [127:0]         digest [NUM_CORES];

  // Digest bus unpacked into one 128-bit word per core
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_digest
    assign digest[g] = bus.core_digest[g*128 +: 128];
  end

  // Round-robin pick: first free core at or after the pointer, wrapping
  always_comb begin
    int probe;
    probe     = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int off = 0; off < NUM_CORES; off++) begin
      probe = int'(rr_q) + off;
      if (probe >= NUM_CORES) probe = probe - NUM_CORES;
      if (!sel_found && !alloc_q[probe[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = probe[IDX_W-1:0];
      end
    end
  end

  // Result arbitration: lowest-index pending core is retired first
  always_comb begin
    res_found = 1'b0;
    res_idx   = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (pend_q[j[IDX_W-1:0]]) begin
        res_found = 1'b1;
        res_idx   = j[IDX_W-1:0];
      end
    end
  end

  assign accept = bus.cand_valid & cand_ready_s;

  // Datapath next state: dispatch, completion capture, result retirement, target load
  always_comb begin
    clr_mask = '0;
    if (res_found) clr_mask[res_idx] = 1'b1;

    // A done on an unallocated core is dropped; retirement clears both masks together
    pend_d  = (pend_q | (bus.core_done & alloc_q)) & ~clr_mask;
    alloc_d = alloc_q & ~clr_mask;

    start_d = '0;
    cdata_d = cdata_q;
    rr_d    = rr_q;
    if (accept) begin
      alloc_d[sel_idx] = 1'b1;
      start_d[sel_idx] = 1'b1;
      cdata_d          = bus.cand_data;
      rr_d             = (sel_idx == IDX_W'(NUM_CORES - 1)) ? '0 : sel_idx + 1'b1;
    end

    mv_d     = res_found && (digest[res_idx] == target_q);
    mtag_d   = res_found ? tag_q[res_idx] : mtag_q;
    target_d = bus.target_load ? bus.target_hash : target_q;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
      alloc_q  <= '0;
      pend_q   <= '0;
      start_q  <= '0;
      cdata_q  <= '0;
      rr_q     <= '0;
      mv_q     <= 1'b0;
      mtag_q   <= '0;
    end else begin
      target_q <= target_d;
      alloc_q  <= alloc_d;
      pend_q   <= pend_d;
      start_q  <= start_d;
      cdata_q  <= cdata_d;
      rr_q     <= rr_d;
      mv_q     <= mv_d;
      mtag_q   <= mtag_d;
    end
  end

  // Per-core tag slots: rewritten only when that core is dispatched again
  always_ff @(posedge clk) begin
    if (accept) tag_q[sel_idx] <= bus.cand_tag;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM next state: drain waits for every allocated and pending core to retire
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if ((alloc_q == '0) && (pend_q == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs: a dispatch cycle blocks the next one so starts are never adjacent
  always_comb begin
    cand_ready_s = 1'b0;
    drain_done_s = 1'b0;
    case (state_q)
      ST_RUN:  cand_ready_s = sel_found && (start_q == '0);
      ST_DONE: drain_done_s = 1'b1;
      default: ;
    endcase
  end

`ifdef MD5_DISPATCH_MATCH_COUNT_EN
  logic [TAG_W-1:0] mcnt_q, mcnt_d;

  // Match counter: counts reported matches, saturates, restarts with a new target
  always_comb begin
    mcnt_d = mcnt_q;
    if (bus.target_load)             mcnt_d = '0;
    else if (mv_q && (mcnt_q != '1)) mcnt_d = mcnt_q + TAG_W'(1);
  end

  // Match counter register
  always_ff @(posedge clk) begin
    if (reset) mcnt_q <= '0;
    else       mcnt_q <= mcnt_d;
  end

  assign bus.match_count = mcnt_q;
`endif

  assign bus.cand_ready  = cand_ready_s;
  assign bus.drain_done  = drain_done_s;
  assign bus.core_start  = start_q;
  assign bus.core_data   = cdata_q;
  assign bus.match_valid = mv_q;
  assign bus.match_tag   = mtag_q;
  assign bus.busy        = (|alloc_q) | (|pend_q);

endmodule

// File: tb/tb_md5_dispatch.sv
// Testbench for md5_dispatch: directed sequence with randomized payloads, tags and digests,
// checked against a core-occupancy reference model.
module tb_md5_dispatch;
  localparam int NC = 4;
  localparam int DW = 448;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic reset;

  md5_dispatch_if #(.NUM_CORES(NC), .DATA_W(DW), .TAG_W(TW)) bus ();

  md5_dispatch #(.NUM_CORES(NC), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [127:0] dig_m [NC];
  assign bus.core_digest = {dig_m[3], dig_m[2], dig_m[1], dig_m[0]};

  int checks = 0;
  int errors = 0;

  // Reference model: which cores hold a candidate, their tags, the rotation start, target, match count
  bit          m_alloc [NC];
  logic [TW-1:0] m_tag [NC];
  int          m_rr;
  logic [127:0] m_target;
  int          m_count;

  task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick();
    for (int k = 0; k < NC; k++)
      if (!m_alloc[(m_rr + k) % NC]) return (m_rr + k) % NC;
    return -1;
  endfunction

  function automatic logic [NC-1:0] onehot(input int c);
    logic [NC-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic int n_alloc();
    int n;
    n = 0;
    for (int k = 0; k < NC; k++) n += int'(m_alloc[k]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < NC; k++) m_alloc[k] = 1'b0;
    m_rr     = 0;
    m_target = '0;
    m_count  = 0;
  endtask

  task automatic load_target(input logic [127:0] t);
    bus.target_load = 1'b1;
    bus.target_hash = t;
    tick();
    bus.target_load = 1'b0;
    m_target = t;
    m_count  = 0;
  endtask

  task automatic offer(input logic [TW-1:0] tag);
    logic [DW-1:0] d;
    int w;
    int c;
    d = rand_data();
    bus.cand_valid = 1'b1;
    bus.cand_data  = d;
    bus.cand_tag   = tag;
    w = 0;
    while (bus.cand_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("offer_ready", bus.cand_ready, 1'b1);
    c = pick();
    tick();
    bus.cand_valid = 1'b0;
    if (c >= 0) begin
      chk("dispatch_start", bus.core_start, onehot(c));
      chk("dispatch_data", bus.core_data, d);
      m_alloc[c] = 1'b1;
      m_tag[c]   = tag;
      m_rr       = (c + 1) % NC;
    end
    chk("ready_after_start", bus.cand_ready, 1'b0);
    chk("busy_after_start", bus.busy, 1'b1);
  endtask

  task automatic complete(input logic [NC-1:0] mask);
    logic hit;
    bus.core_done = mask;
    tick();
    bus.core_done = '0;
    chk("mv_before_result", bus.match_valid, 1'b0);
    for (int i = 0; i < NC; i++) begin
      if (mask[i] && m_alloc[i]) begin
        tick();
        hit = (dig_m[i] == m_target);
        chk("result_mv", bus.match_valid, hit);
        if (hit) begin
          chk("result_tag", bus.match_tag, m_tag[i]);
          m_count++;
        end
        m_alloc[i] = 1'b0;
      end
    end
    tick();
    chk("mv_after_results", bus.match_valid, 1'b0);
    chk("busy_after_results", bus.busy, n_alloc() != 0);
`ifdef MD5_DISPATCH_MATCH_COUNT_EN
    chk("match_count", bus.match_count, m_count);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d5;
    int c;
    reset           = 1'b1;
    bus.target_load = 1'b0;
    bus.target_hash = '0;
    bus.cand_valid  = 1'b0;
    bus.cand_data   = '0;
    bus.cand_tag    = '0;
    bus.drain_req   = 1'b0;
    bus.core_done   = '0;
    for (int k = 0; k < NC; k++) dig_m[k] = '0;

    // Reset state
    do_reset();
    chk("rst_core_start", bus.core_start, '0);
    chk("rst_core_data", bus.core_data, '0);
    chk("rst_match_valid", bus.match_valid, 1'b0);
    chk("rst_match_tag", bus.match_tag, '0);
    chk("rst_drain_done", bus.drain_done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cand_ready", bus.cand_ready, 1'b1);
`ifdef MD5_DISPATCH_MATCH_COUNT_EN
    chk("rst_match_count", bus.match_count, '0);
`endif

    // 1: single candidate, matching digest
    load_target(128'ha2004f37730b9445670a738fa0fc9ee5);
    offer(16'h0007);
    chk("t1_start", bus.core_start, 4'b0001);
    tick();
    chk("t1_start_pulse", bus.core_start, 4'b0000);
    repeat (9) tick();
    dig_m[0] = m_target;
    complete(4'b0001);

    // 2: five back-to-back candidates, fifth waits for a free core
    do_reset();
    load_target(rand128());
    for (int t = 0; t < 4; t++) begin
      offer(TW'(t));
      chk("t2_seq", bus.core_start, onehot(t));
    end
    d5 = rand_data();
    bus.cand_valid = 1'b1;
    bus.cand_tag   = 16'd4;
    bus.cand_data  = d5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_held_ready", bus.cand_ready, 1'b0);
      chk("t2_held_start", bus.core_start, '0);
    end
    dig_m[0] = rand128();
    bus.core_done = 4'b0001;
    tick();
    bus.core_done = '0;
    chk("t2_pending_ready", bus.cand_ready, 1'b0);
    tick();
    chk("t2_free_mv", bus.match_valid, dig_m[0] == m_target);
    chk("t2_free_ready", bus.cand_ready, 1'b1);
    m_alloc[0] = 1'b0;
    c = pick();
    tick();
    bus.cand_valid = 1'b0;
    chk("t2_fifth_start", bus.core_start, 4'b0001);
    chk("t2_fifth_model", bus.core_start, onehot(c));
    chk("t2_fifth_data", bus.core_data, d5);
    m_alloc[c] = 1'b1;
    m_tag[c]   = 16'd4;
    m_rr       = (c + 1) % NC;
    dig_m[0] = m_target;
    dig_m[1] = rand128();
    dig_m[2] = rand128();
    dig_m[3] = m_target;
    complete(4'b1111);

    // 3: simultaneous completion on cores 1 and 3, both matching
    do_reset();
    load_target(rand128());
    for (int t = 0; t < 4; t++) offer(TW'($urandom));
    dig_m[1] = m_target;
    dig_m[3] = m_target;
    complete(4'b1010);

    // 4: non-matching all-zero digest, core reused on the next cycle
    dig_m[0] = '0;
    bus.core_done = 4'b0001;
    tick();
    bus.core_done = '0;
    tick();
    chk("t4_no_match", bus.match_valid, 1'b0);
    chk("t4_ready", bus.cand_ready, 1'b1);
    m_alloc[0] = 1'b0;
    offer(TW'($urandom));
    chk("t4_reuse_core0", bus.core_start, 4'b0001);
    dig_m[0] = rand128();
    dig_m[2] = m_target;
    complete(4'b1111);

    // 5: drain with three cores outstanding, then drain with nothing outstanding
    do_reset();
    load_target(rand128());
    for (int t = 0; t < 3; t++) offer(TW'($urandom));
    tick();
    bus.drain_req = 1'b1;
    tick();
    bus.drain_req = 1'b0;
    chk("t5_ready_drain", bus.cand_ready, 1'b0);
    chk("t5_dd_early", bus.drain_done, 1'b0);
    dig_m[0] = rand128();
    dig_m[1] = m_target;
    complete(4'b0001);
    complete(4'b0010);
    chk("t5_still_draining", bus.drain_done, 1'b0);
    dig_m[2] = m_target;
    bus.core_done = 4'b0100;
    tick();
    bus.core_done = '0;
    tick();
    chk("t5_last_mv", bus.match_valid, 1'b1);
    chk("t5_last_tag", bus.match_tag, m_tag[2]);
    chk("t5_dd_at_last", bus.drain_done, 1'b0);
    m_alloc[2] = 1'b0;
    tick();
    chk("t5_dd_pulse", bus.drain_done, 1'b1);
    chk("t5_busy_idle", bus.busy, 1'b0);
    chk("t5_ready_done", bus.cand_ready, 1'b0);
    tick();
    chk("t5_dd_end", bus.drain_done, 1'b0);
    chk("t5_ready_run", bus.cand_ready, 1'b1);
    bus.drain_req = 1'b1;
    tick();
    bus.drain_req = 1'b0;
    chk("t5_empty_dd_edge1", bus.drain_done, 1'b0);
    tick();
    chk("t5_empty_dd_edge2", bus.drain_done, 1'b1);
    tick();
    chk("t5_empty_dd_edge3", bus.drain_done, 1'b0);

    // 6: reset mid-operation, stale completions ignored
    do_reset();
    load_target(rand128());
    offer(TW'($urandom));
    offer(TW'($urandom));
    do_reset();
    chk("t6_start", bus.core_start, '0);
    chk("t6_data", bus.core_data, '0);
    chk("t6_tag", bus.match_tag, '0);
    chk("t6_busy", bus.busy, 1'b0);
    dig_m[0] = '0;
    dig_m[1] = '0;
    complete(4'b0011);
    chk("t6_stale_tag", bus.match_tag, '0);
`ifdef MD5_DISPATCH_MATCH_COUNT_EN
    load_target(rand128());
    for (int t = 0; t < 3; t++) offer(TW'($urandom));
    for (int k = 0; k < 3; k++) dig_m[k] = m_target;
    complete(4'b0111);
    chk("t6_count3", bus.match_count, 16'd3);
    load_target(rand128());
    chk("t6_count_clear", bus.match_count, '0);
`endif

    // Random mix of dispatches and single completions
    do_reset();
    load_target(rand128());
    for (int it = 0; it < 24; it++) begin
      if (n_alloc() == 0 || (n_alloc() < NC && $urandom_range(0, 2) != 0)) begin
        offer(TW'($urandom));
      end else begin
        c = $urandom_range(0, NC - 1);
        while (!m_alloc[c]) c = (c + 1) % NC;
        dig_m[c] = ($urandom_range(0, 1) == 1) ? m_target : rand128();
        complete(onehot(c));
      end
    end
    begin
      logic [NC-1:0] rest;
      rest = '0;
      for (int k = 0; k < NC; k++) begin
        rest[k] = m_alloc[k];
        dig_m[k] = m_target;
      end
      complete(rest);
    end
    chk("final_busy", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
